// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one data memory between the CPU load/store port (m0) and a
//   secondary master (m1: loader / DMA / debug). m0 has fixed priority.
//   A saturating wait counter lets m1 win once it has been denied
//   MAX_WAIT cycles in a row.
//
// Ports
//   clk, reset_b       clock, async active-low reset
//   m0_* / m1_*        request: req, we, addr, sz, wdata
//                      response: gnt, rvalid, rdata (m0 also has stall)
//   mem_*              dmem side: addr, rd_en, wr_en, sz, din, dout
//
// Grants are combinational in the request cycle. Read data is captured
// at the grant posedge and presented with a one-cycle rvalid pulse.
module dmem_arbiter #(
    parameter int DMEM_ADDR_WIDTH = 10,
    parameter int MAX_WAIT        = 4
) (
    input  logic                       clk,
    input  logic                       reset_b,
    input  logic                       m0_req,
    input  logic                       m0_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] m0_addr,
    input  logic [1:0]                 m0_sz,
    input  logic [31:0]                m0_wdata,
    output logic                       m0_gnt,
    output logic                       m0_stall,
    output logic                       m0_rvalid,
    output logic [31:0]                m0_rdata,
    input  logic                       m1_req,
    input  logic                       m1_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] m1_addr,
    input  logic [1:0]                 m1_sz,
    input  logic [31:0]                m1_wdata,
    output logic                       m1_gnt,
    output logic                       m1_rvalid,
    output logic [31:0]                m1_rdata,
    output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
    output logic                       mem_rd_en,
    output logic                       mem_wr_en,
    output logic [1:0]                 mem_sz,
    output logic [31:0]                mem_din,
    input  logic [31:0]                mem_dout
);

    localparam int            CW       = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]    rd_pend_q, rd_pend_d;     // [0] = m0, [1] = m1
    logic [31:0]   m0_rdata_q, m0_rdata_d;
    logic [31:0]   m1_rdata_q, m1_rdata_d;
    logic          force1;

    always_comb begin
        // m1 overrides m0 only after MAX_WAIT consecutive denials.
        // Grants are gated by reset_b so nothing reaches dmem during reset.
        force1 = m1_req && (wait_cnt_q == WAIT_MAX);
        m1_gnt = reset_b && m1_req && (!m0_req || force1);
        m0_gnt = reset_b && m0_req && !m1_gnt;
        m0_stall = m0_req && !m0_gnt;

        // With no grant the m0 fields still drive the bus; enables are 0.
        if (m1_gnt) begin
            mem_addr = m1_addr;
            mem_sz   = m1_sz;
            mem_din  = m1_wdata;
        end else begin
            mem_addr = m0_addr;
            mem_sz   = m0_sz;
            mem_din  = m0_wdata;
        end
        mem_rd_en = (m0_gnt && !m0_we) || (m1_gnt && !m1_we);
        mem_wr_en = (m0_gnt &&  m0_we) || (m1_gnt &&  m1_we);

        // Counter tracks consecutive m1 denials; a grant or a withdrawn
        // request restarts it.
        wait_cnt_d = wait_cnt_q;
        if (!m1_req || m1_gnt)
            wait_cnt_d = '0;
        else if (wait_cnt_q != WAIT_MAX)
            wait_cnt_d = wait_cnt_q + CW'(1);

        rd_pend_d  = {m1_gnt && !m1_we, m0_gnt && !m0_we};
        m0_rdata_d = rd_pend_d[0] ? mem_dout : m0_rdata_q;
        m1_rdata_d = rd_pend_d[1] ? mem_dout : m1_rdata_q;
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wait_cnt_q <= '0;
            rd_pend_q  <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rd_pend_q  <= rd_pend_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign m0_rvalid = rd_pend_q[0];
    assign m1_rvalid = rd_pend_q[1];
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a byte-array dmem stub on the
// memory side, a behavioural model (denial count, reference memory,
// pending-read flags) checked every negedge, directed scenarios with
// literal expectations, then a randomized phase.
module tb_dmem_arbiter;
    localparam int AW = 10;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset_b;
    logic          m0_req, m0_we, m1_req, m1_we;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [1:0]    m0_sz, m1_sz;
    logic [31:0]   m0_wdata, m1_wdata;
    logic          m0_gnt, m0_stall, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0]   m0_rdata, m1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en, mem_wr_en;
    logic [1:0]    mem_sz;
    logic [31:0]   mem_din, mem_dout;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.DMEM_ADDR_WIDTH(AW), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset_b(reset_b),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sz(m0_sz),
        .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_stall(m0_stall),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sz(m1_sz),
        .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
        .mem_sz(mem_sz), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // dmem stub: combinational raw 4-byte little-endian read, sized write.
    logic [7:0] dm [1024] = '{default: 8'h00};
    always_comb mem_dout = {dm[mem_addr + 10'd3], dm[mem_addr + 10'd2],
                            dm[mem_addr + 10'd1], dm[mem_addr]};
    always @(posedge clk) begin
        if (mem_wr_en) begin
            dm[mem_addr] <= mem_din[7:0];
            if (mem_sz != 2'd0) dm[mem_addr + 10'd1] <= mem_din[15:8];
            if (mem_sz >= 2'd2) begin
                dm[mem_addr + 10'd2] <= mem_din[23:16];
                dm[mem_addr + 10'd3] <= mem_din[31:24];
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  ref_mem [1024] = '{default: 8'h00};
    int          denied = 0;      // consecutive cycles m1 asked and lost
    bit          rv0 = 0, rv1 = 0;
    logic [31:0] rd0 = 0, rd1 = 0;
    bit          e0, e1;

    function automatic logic [31:0] ref_read(input logic [AW-1:0] a);
        return {ref_mem[a + 10'd3], ref_mem[a + 10'd2], ref_mem[a + 10'd1], ref_mem[a]};
    endfunction

    task automatic ref_write(input logic [AW-1:0] a, input logic [1:0] sz, input logic [31:0] d);
        int n;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        for (int i = 0; i < n; i++) ref_mem[a + AW'(i)] = d[8*i +: 8];
    endtask

    always @(negedge clk) begin
        if (!reset_b) begin
            chk("rst_outputs", {26'd0, m0_gnt, m1_gnt, mem_rd_en, mem_wr_en, m0_rvalid, m1_rvalid}, 32'd0);
            chk("rst_m0_rdata", m0_rdata, 32'd0);
            chk("rst_m1_rdata", m1_rdata, 32'd0);
            denied = 0; rv0 = 0; rv1 = 0; rd0 = 0; rd1 = 0;
        end else begin
            e1 = m1_req && (!m0_req || denied >= MW);
            e0 = m0_req && !e1;
            chk("m0_gnt", {31'd0, m0_gnt}, {31'd0, e0});
            chk("m1_gnt", {31'd0, m1_gnt}, {31'd0, e1});
            chk("m0_stall", {31'd0, m0_stall}, {31'd0, m0_req && !e0});
            chk("mem_rd_en", {31'd0, mem_rd_en}, {31'd0, (e0 && !m0_we) || (e1 && !m1_we)});
            chk("mem_wr_en", {31'd0, mem_wr_en}, {31'd0, (e0 && m0_we) || (e1 && m1_we)});
            if (e0 || e1) begin
                chk("mem_addr", {22'd0, mem_addr}, {22'd0, e1 ? m1_addr : m0_addr});
                chk("mem_sz", {30'd0, mem_sz}, {30'd0, e1 ? m1_sz : m0_sz});
                chk("mem_din", mem_din, e1 ? m1_wdata : m0_wdata);
            end
            chk("m0_rvalid", {31'd0, m0_rvalid}, {31'd0, rv0});
            chk("m1_rvalid", {31'd0, m1_rvalid}, {31'd0, rv1});
            chk("m0_rdata", m0_rdata, rd0);
            chk("m1_rdata", m1_rdata, rd1);
            // effect of the coming posedge
            rv0 = e0 && !m0_we;
            rv1 = e1 && !m1_we;
            if (rv0) rd0 = ref_read(m0_addr);
            if (rv1) rd1 = ref_read(m1_addr);
            if (e0 && m0_we) ref_write(m0_addr, m0_sz, m0_wdata);
            if (e1 && m1_we) ref_write(m1_addr, m1_sz, m1_wdata);
            denied = (m1_req && !e1) ? denied + 1 : 0;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    task automatic set_m0(input logic r, input logic w, input logic [AW-1:0] a,
                          input logic [1:0] s, input logic [31:0] d);
        m0_req = r; m0_we = w; m0_addr = a; m0_sz = s; m0_wdata = d;
    endtask

    task automatic set_m1(input logic r, input logic w, input logic [AW-1:0] a,
                          input logic [1:0] s, input logic [31:0] d);
        m1_req = r; m1_we = w; m1_addr = a; m1_sz = s; m1_wdata = d;
    endtask

    int  first;
    bit  g0, g1;

    initial begin
        reset_b = 1'b0;
        set_m0(0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0);
        repeat (3) tick();
        samp();
        chk("reset_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        chk("reset_m0_rdata", m0_rdata, 32'd0);
        tick();
        reset_b = 1'b1;

        // uncontended word write then read
        set_m0(1, 1, 10'h010, 2'b10, 32'hDEADBEEF);
        samp();
        chk("wr_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        chk("wr_m0_stall", {31'd0, m0_stall}, 32'd0);
        tick();
        set_m0(1, 0, 10'h010, 2'b10, 0);
        samp();
        chk("rd_m0_gnt", {31'd0, m0_gnt}, 32'd1);
        chk("rd_mem_rd_en", {31'd0, mem_rd_en}, 32'd1);
        tick();
        set_m0(0, 0, 0, 0, 0);
        samp();
        chk("rd_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
        chk("rd_m0_rdata", m0_rdata, 32'hDEADBEEF);
        chk("rd_m1_rdata", m1_rdata, 32'd0);
        tick();
        samp();
        chk("rd_rvalid_pulse", {31'd0, m0_rvalid}, 32'd0);
        chk("rd_rdata_hold", m0_rdata, 32'hDEADBEEF);
        tick();

        // contention: m0,m0,m0,m0,m1 repeating
        set_m0(1, 0, 10'h040, 2'b10, 0);
        set_m1(1, 0, 10'h080, 2'b10, 0);
        for (int i = 0; i < 10; i++) begin
            samp();
            chk("cont_m1_gnt", {31'd0, m1_gnt}, {31'd0, (i % 5) == 4});
            chk("cont_m0_stall", {31'd0, m0_stall}, {31'd0, (i % 5) == 4});
            if (m1_gnt) chk("cont_wait_cnt", {29'd0, dut.wait_cnt_q}, 32'd4);
            tick();
        end
        set_m1(0, 0, 0, 0, 0);
        tick();

        // m1 withdraws after 2 cycles, re-asserts one cycle later
        set_m1(1, 0, 10'h080, 2'b10, 0);
        tick(); tick();
        set_m1(0, 0, 10'h080, 2'b10, 0);
        tick();
        set_m1(1, 0, 10'h080, 2'b10, 0);
        first = -1;
        for (int i = 0; i < 12 && first < 0; i++) begin
            samp();
            if (m1_gnt) first = i;
            tick();
        end
        chk("withdraw_first_gnt", first, 32'd4);
        set_m0(0, 0, 0, 0, 0);
        set_m1(0, 0, 0, 0, 0);
        tick();

        // sized store passthrough from m1
        set_m1(1, 1, 10'h003, 2'b01, 32'h0000ABCD);
        samp();
        chk("sz_mem_sz", {30'd0, mem_sz}, 32'd1);
        chk("sz_mem_addr", {22'd0, mem_addr}, 32'h003);
        chk("sz_mem_din", mem_din, 32'h0000ABCD);
        chk("sz_mem_wr_en", {31'd0, mem_wr_en}, 32'd1);
        tick();
        set_m1(0, 0, 0, 0, 0);
        samp();
        chk("sz_wr_en_once", {31'd0, mem_wr_en}, 32'd0);
        tick();

        // m1 write at wait_cnt==MAX_WAIT races an m0 read of the same address
        set_m1(1, 1, 10'h020, 2'b10, 32'h12345678);
        set_m0(1, 0, 10'h100, 2'b10, 0);
        repeat (4) tick();
        set_m0(1, 0, 10'h020, 2'b10, 0);
        samp();
        chk("race_m1_first", {30'd0, m1_gnt, m0_gnt}, 32'b10);
        tick();
        set_m1(0, 0, 0, 0, 0);
        samp();
        chk("race_m0_next", {31'd0, m0_gnt}, 32'd1);
        tick();
        set_m0(0, 0, 0, 0, 0);
        samp();
        chk("race_m0_rdata", m0_rdata, 32'h12345678);
        tick();

        // reset in the cycle after an m0 read grant
        set_m0(1, 0, 10'h010, 2'b10, 0);
        tick();
        reset_b = 1'b0;
        set_m0(1, 1, 10'h010, 2'b10, 32'h55555555);
        #1;
        chk("rstmid_m0_rvalid", {31'd0, m0_rvalid}, 32'd0);
        chk("rstmid_m0_rdata", m0_rdata, 32'd0);
        chk("rstmid_wr_en", {31'd0, mem_wr_en}, 32'd0);
        tick(); tick();
        reset_b = 1'b1;
        set_m0(1, 0, 10'h010, 2'b10, 0);
        tick();
        set_m0(0, 0, 0, 0, 0);
        samp();
        chk("rstmid_no_commit", m0_rdata, 32'hDEADBEEF);
        tick();

        // randomized traffic; requests held until granted, m1 may withdraw
        for (int c = 0; c < 3000; c++) begin
            samp();
            g0 = m0_gnt; g1 = m1_gnt;
            tick();
            if (g0 || !m0_req)
                set_m0($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                       AW'($urandom_range(0, 63)), 2'($urandom_range(0, 2)), $urandom);
            if (g1 || !m1_req || $urandom_range(0, 15) == 0)
                set_m1($urandom_range(0, 2) != 0, 1'($urandom_range(0, 1)),
                       AW'($urandom_range(0, 63)), 2'($urandom_range(0, 2)), $urandom);
        end
        samp();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
